adc_capture_seq: RTL and testbench
==================================

Name: adc_capture_seq

Overview:
- Capture sequencer in front of the 4-channel ADC data selector (250 MHz ADC clock domain).
- Arms on software command, waits for a trigger rising edge, applies a programmable post-trigger delay, then holds the selector's capture enable for a fixed number of decimated sample beats. It then reports done and frame count.
- Also flags overruns when the downstream user interface is not ready.

Parameters:
- CNT_W, 16: width of delay, record-length, beat and frame counters.
- DE_W, 9: width of the decimation indicator. It matches the selector's decimation input.

Ports:
- CpSl_Clk_i  in  1  ADC/user clock; all logic on the rising edge.
- CpSl_Rst_iN  in  1  asynchronous active-low reset.
- CpSl_Arm_i  in  1  arm request; sampled only in IDLE.
- CpSl_Abort_i  in  1  abort; highest priority.
- CpSl_Trig_i  in  1  external trigger level, already synchronous to CpSl_Clk_i.
- CpSv_Delay_i  in  CNT_W  post-trigger delay in cycles.
- CpSv_RecLen_i  in  CNT_W  beats per record; 0 is treated as 1.
- CpSv_DeInd_i  in  DE_W  decimation; one strobe every DeInd+1 cycles.
- CpSl_UsrRdy_i  in  1  downstream ready.
- CpSl_CapEn_o  out  1  capture enable to the data selector trigger input.
- CpSl_SmpStb_o  out  1  decimated sample strobe.
- CpSl_Busy_o  out  1  state is not IDLE.
- CpSl_Done_o  out  1  one-cycle pulse at record completion.
- CpSl_Ovf_o  out  1  sticky overrun flag.
- CpSv_BeatCnt_o  out  CNT_W  beats captured in the current record.
- CpSv_FrameCnt_o  out  CNT_W  completed records; wraps at 2^CNT_W.

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Trigger delay register Trig_d = 1, so a trigger held high through reset does not fire.
- Outputs are decoded from registers only; there is no combinational input-to-output path.
- FSM states: IDLE, ARMED, DELAY, CAPTURE, DONE.
- IDLE:
  - Arm_i=1 latches Delay_i, RecLen_i (0 becomes 1) and DeInd_i.
  - It clears BeatCnt and Ovf, and moves to ARMED next cycle.
  - Later input changes do not affect the running record.
- ARMED:
  - A rising edge means Trig_i=1 and Trig_d=0.
  - On a rising edge, go to DELAY if the latched delay is greater than 0, else to CAPTURE.
  - A trigger edge in the same cycle as entering ARMED is not seen; the edge must be sampled while in ARMED.
- DELAY:
  - The counter loads the latched delay and decrements once per cycle.
  - DELAY therefore lasts exactly Delay cycles, then the block moves to CAPTURE.
- CAPTURE:
  - CapEn_o=1 throughout.
  - The decimation counter is 0 on entry.
  - SmpStb_o=1 when the counter is 0. The counter counts 0..DeInd and then wraps.
  - Each strobe increments BeatCnt.
  - On the strobe where BeatCnt+1 equals RecLen, go to DONE.
  - CAPTURE length is (RecLen-1)*(DeInd+1)+1 cycles.
- DONE:
  - Lasts one cycle, with Done_o=1, CapEn_o=0 and FrameCnt incremented.
  - Next state is IDLE.
  - BeatCnt holds its final value until the next arm.
- Latency: a trigger edge sampled at edge k gives CapEn_o=1 from cycle k+1+Delay.
- Overrun:
  - Ovf sets on any cycle with SmpStb_o=1 and UsrRdy_i=0.
  - It stays set until the next accepted arm.
  - An overrun does not stop the capture.
- Abort:
  - Abort_i=1 in any state forces IDLE next cycle, with CapEn_o and SmpStb_o low from that cycle.
  - There is no Done pulse and FrameCnt is unchanged.
  - Abort has priority over Arm and Trig in the same cycle.
- Ignored events:
  - Arm_i outside IDLE is ignored.
  - Trigger edges outside ARMED are ignored; re-triggering mid-capture has no effect.
- Asynchronous reset mid-capture: CapEn_o drops immediately and all counters clear.

Optional Feature:
- Macro: ADC_CAPTURE_SEQ_AUTO_REARM_EN.
- When defined: DONE goes to ARMED instead of IDLE. The latched configuration is reused, BeatCnt and Ovf are cleared on re-entry, and Busy_o stays 1. Abort is the only exit back to IDLE.
- When undefined: DONE always goes to IDLE, as described above.

Test Plan:
- Delay=3, RecLen=4, DeInd=0, trigger edge sampled at cycle 10 -> CapEn high for cycles 14..17; 4 strobes on consecutive cycles; Done at cycle 18; FrameCnt=1.
- Delay=0, RecLen=3, DeInd=4 -> CapEn high for 11 cycles starting the cycle after the trigger; strobes at offsets 0, 5 and 10; BeatCnt ends at 3.
- RecLen=0, DeInd=2 -> behaves as RecLen=1: one strobe, one CapEn cycle, then Done.
- UsrRdy=0 during the 2nd strobe of 4 -> Ovf=1 until the next Arm; capture still completes with Done and BeatCnt=4.
- Abort asserted on the 3rd CAPTURE cycle -> IDLE next cycle, no Done, FrameCnt unchanged. Trig held high through Arm and ARMED gives no capture until it is driven low and then high again.
- With ADC_CAPTURE_SEQ_AUTO_REARM_EN defined and 3 trigger pulses -> 3 Done pulses, FrameCnt=3, and Busy stays 1 between records.

Source files
------------

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: capture sequencer in front of the 4-channel ADC data selector.
// The block is armed by a software command and then waits for a trigger rising edge.
// After the programmable post-trigger delay it holds capture enable for a fixed number
// of decimated sample beats. It then pulses done and bumps the frame count.
// Configuration is latched at arm time, so later input changes do not affect a running
// record.
//
// Optional feature: define ADC_CAPTURE_SEQ_AUTO_REARM_EN to return from DONE to ARMED.
// The latched configuration is then reused, and abort is the only way back to IDLE.
//
// Ports:
//   CpSl_Clk_i       ADC/user clock, rising edge
//   CpSl_Rst_iN      asynchronous active-low reset
//   CpSl_Arm_i       arm request (IDLE only)
//   CpSl_Abort_i     abort, highest priority
//   CpSl_Trig_i      trigger level, synchronous to CpSl_Clk_i
//   CpSv_Delay_i     post-trigger delay in cycles
//   CpSv_RecLen_i    beats per record (0 treated as 1)
//   CpSv_DeInd_i     decimation: one strobe every DeInd+1 cycles
//   CpSl_UsrRdy_i    downstream ready
//   CpSl_CapEn_o     capture enable to the data selector
//   CpSl_SmpStb_o    decimated sample strobe
//   CpSl_Busy_o      sequencer not idle
//   CpSl_Done_o      one-cycle record-complete pulse
//   CpSl_Ovf_o       sticky overrun flag
//   CpSv_BeatCnt_o   beats captured in the current record
//   CpSv_FrameCnt_o  completed records (wrapping)
module adc_capture_seq #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DE_W  = 9
) (
  input  logic             CpSl_Clk_i,
  input  logic             CpSl_Rst_iN,
  input  logic             CpSl_Arm_i,
  input  logic             CpSl_Abort_i,
  input  logic             CpSl_Trig_i,
  input  logic [CNT_W-1:0] CpSv_Delay_i,
  input  logic [CNT_W-1:0] CpSv_RecLen_i,
  input  logic [DE_W-1:0]  CpSv_DeInd_i,
  input  logic             CpSl_UsrRdy_i,
  output logic             CpSl_CapEn_o,
  output logic             CpSl_SmpStb_o,
  output logic             CpSl_Busy_o,
  output logic             CpSl_Done_o,
  output logic             CpSl_Ovf_o,
  output logic [CNT_W-1:0] CpSv_BeatCnt_o,
  output logic [CNT_W-1:0] CpSv_FrameCnt_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e           state_q,     state_d;
  logic             trig_dly_q;
  logic [CNT_W-1:0] delay_q,     delay_d;
  logic [CNT_W-1:0] reclen_q,    reclen_d;
  logic [DE_W-1:0]  deind_q,     deind_d;
  logic [CNT_W-1:0] dly_cnt_q,   dly_cnt_d;
  logic [DE_W-1:0]  dec_cnt_q,   dec_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             ovf_q,       ovf_d;
  logic             cap_en_q,    cap_en_d;
  logic             smp_stb_q,   smp_stb_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             trig_rise;
  logic [CNT_W-1:0] beat_inc;

  assign trig_rise = CpSl_Trig_i & ~trig_dly_q;
  assign beat_inc  = beat_cnt_q + CNT_W'(1);

  // State register and all datapath/output registers
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      state_q     <= S_IDLE;
      trig_dly_q  <= 1'b1;   // a trigger held high through reset must not look like an edge
      delay_q     <= '0;
      reclen_q    <= '0;
      deind_q     <= '0;
      dly_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      cap_en_q    <= 1'b0;
      smp_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_dly_q  <= CpSl_Trig_i;
      delay_q     <= delay_d;
      reclen_q    <= reclen_d;
      deind_q     <= deind_d;
      dly_cnt_q   <= dly_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      cap_en_q    <= cap_en_d;
      smp_stb_q   <= smp_stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    reclen_d    = reclen_q;
    deind_d     = deind_q;
    dly_cnt_d   = dly_cnt_q;
    dec_cnt_d   = '0;        // decimation counter is zero whenever not mid-capture
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    // Overrun: the strobe currently on the output was not accepted downstream
    ovf_d       = ovf_q | (smp_stb_q & ~CpSl_UsrRdy_i);

    if (CpSl_Abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (CpSl_Arm_i) begin
            delay_d    = CpSv_Delay_i;
            reclen_d   = (CpSv_RecLen_i == '0) ? CNT_W'(1) : CpSv_RecLen_i;
            deind_d    = CpSv_DeInd_i;
            beat_cnt_d = '0;
            ovf_d      = 1'b0;
            state_d    = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_rise) begin
            if (delay_q != '0) begin
              dly_cnt_d = delay_q;
              state_d   = S_DELAY;
            end else begin
              state_d   = S_CAPTURE;
            end
          end
        end
        S_DELAY: begin
          dly_cnt_d = dly_cnt_q - CNT_W'(1);
          if (dly_cnt_q == CNT_W'(1)) begin
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // Strobe beat whenever the decimation counter is at zero
          if (dec_cnt_q == '0) begin
            beat_cnt_d = beat_inc;
            if (beat_inc == reclen_q) begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
              state_d     = S_DONE;
            end
          end
          if (state_d == S_CAPTURE) begin
            dec_cnt_d = (dec_cnt_q == deind_q) ? '0 : dec_cnt_q + DE_W'(1);
          end
        end
        S_DONE: begin
`ifdef ADC_CAPTURE_SEQ_AUTO_REARM_EN
          beat_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = S_ARMED;
`else
          state_d    = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    cap_en_d  = (state_d == S_CAPTURE);
    smp_stb_d = (state_d == S_CAPTURE) && (dec_cnt_d == '0);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  assign CpSl_CapEn_o    = cap_en_q;
  assign CpSl_SmpStb_o   = smp_stb_q;
  assign CpSl_Busy_o     = busy_q;
  assign CpSl_Done_o     = done_q;
  assign CpSl_Ovf_o      = ovf_q;
  assign CpSv_BeatCnt_o  = beat_cnt_q;
  assign CpSv_FrameCnt_o = frame_cnt_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Testbench for adc_capture_seq. Each record's expected output timeline is computed from
// the trigger edge with plain arithmetic and then compared cycle by cycle.
module tb_adc_capture_seq;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DE_W  = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0, abort = 1'b0, trig = 1'b0, rdy = 1'b1;
  logic [CNT_W-1:0] delay = '0, reclen = '0;
  logic [DE_W-1:0]  deind = '0;
  logic             cap_en, smp_stb, busy, done, ovf;
  logic [CNT_W-1:0] beat_cnt, frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int frames_exp = 0;
  logic ovf_model = 1'b0;

  always #5 clk = ~clk;

  adc_capture_seq #(.CNT_W(CNT_W), .DE_W(DE_W)) dut (
    .CpSl_Clk_i     (clk),
    .CpSl_Rst_iN    (rst_n),
    .CpSl_Arm_i     (arm),
    .CpSl_Abort_i   (abort),
    .CpSl_Trig_i    (trig),
    .CpSv_Delay_i   (delay),
    .CpSv_RecLen_i  (reclen),
    .CpSv_DeInd_i   (deind),
    .CpSl_UsrRdy_i  (rdy),
    .CpSl_CapEn_o   (cap_en),
    .CpSl_SmpStb_o  (smp_stb),
    .CpSl_Busy_o    (busy),
    .CpSl_Done_o    (done),
    .CpSl_Ovf_o     (ovf),
    .CpSv_BeatCnt_o (beat_cnt),
    .CpSv_FrameCnt_o(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_capen"}, 32'(cap_en), 32'd0);
    chk({tag, "_stb"},   32'(smp_stb), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
  endtask

  // One record: optional arm, trigger, then a cycle-by-cycle comparison against the timeline.
  // rdy_mode 0: always ready, 1: random stalls, 2: not ready on the 2nd strobe only.
  // abort_cap >= 0 aborts during that 0-based CAPTURE cycle.
  task automatic run_record(input int d, input int l, input int e, input int rdy_mode,
                            input int abort_cap, input bit pre_high, input bit do_arm,
                            input bit auto_mode);
    int lp, p, cap_last, done_rel, abort_rel;
    bit aborted, e_cap, e_stb, e_done, e_busy;
    int e_beat;
    lp       = (l == 0) ? 1 : l;
    p        = e + 1;
    cap_last = d + (lp - 1) * p;
    done_rel = cap_last + 1;
    abort_rel = (abort_cap >= 0) ? d + abort_cap + 1 : -1;

    if (do_arm) begin
      chk("ovf_before_arm", 32'(ovf), 32'(ovf_model));
      delay  = CNT_W'(d);
      reclen = CNT_W'(l);
      deind  = DE_W'(e);
      arm    = 1'b1;
      trig   = pre_high;
      step();
      arm    = 1'b0;
      delay  = CNT_W'($urandom);
      reclen = CNT_W'($urandom);
      deind  = DE_W'($urandom);
      ovf_model = 1'b0;
      chk("arm_busy", 32'(busy), 32'd1);
      chk("arm_ovf", 32'(ovf), 32'd0);
      chk("arm_beat", 32'(beat_cnt), 32'd0);
      chk("arm_capen", 32'(cap_en), 32'd0);
    end
    if (pre_high) begin
      // Level held high since before arm must not be treated as an edge
      repeat (4) begin
        step();
        chk("hold_capen", 32'(cap_en), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
      end
    end
    trig = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      step();
      chk("wait_capen", 32'(cap_en), 32'd0);
    end
    trig = 1'b1;

    for (int rel = 0; rel <= done_rel + 1; rel++) begin
      step();
      aborted = (abort_rel >= 0) && (rel >= abort_rel);
      e_cap   = !aborted && rel >= d && rel <= cap_last;
      e_stb   = e_cap && ((rel - d) % p == 0);
      e_done  = !aborted && rel == done_rel;
      e_busy  = auto_mode ? !aborted : (!aborted && rel <= done_rel);
      if (rel <= d) e_beat = 0;
      else e_beat = ((rel - d + e) / p < lp) ? (rel - d + e) / p : lp;
      if (auto_mode && rel == done_rel + 1) begin
        e_beat = 0;
        ovf_model = 1'b0;
      end
      chk("capen", 32'(cap_en), 32'(e_cap));
      chk("stb", 32'(smp_stb), 32'(e_stb));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      if (!aborted) begin
        chk("beat", 32'(beat_cnt), 32'(e_beat));
        chk("ovf", 32'(ovf), 32'(ovf_model));
      end
      if (e_done) frames_exp++;

      // Inputs for the next edge
      abort = (abort_rel >= 0) && (rel == abort_rel - 1);
      case (rdy_mode)
        1:       rdy = ($urandom_range(0, 4) != 0);
        2:       rdy = !(e_stb && ((rel - d) / p == 1));
        default: rdy = 1'b1;
      endcase
      if (e_stb && !rdy) ovf_model = 1'b1;
      trig = (rel < done_rel) ? 1'($urandom) : 1'b0;
      arm  = (rel <= done_rel && (abort_rel < 0 || rel < abort_rel)) ?
             ($urandom_range(0, 3) == 0) : 1'b0;
    end
    abort = 1'b0;
    arm   = 1'b0;
    trig  = 1'b0;
    rdy   = 1'b1;
    chk("frame", 32'(frame_cnt), 32'(frames_exp));
  endtask

  initial begin
    // Reset with trigger held high
    trig = 1'b1;
    repeat (3) step();
    chk_idle_outputs("rst");
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk_idle_outputs("post_rst");
    trig = 1'b0;
    step();

`ifdef ADC_CAPTURE_SEQ_AUTO_REARM_EN
    run_record(1, 2, 1, 1, -1, 1'b0, 1'b1, 1'b1);
    run_record(1, 2, 1, 1, -1, 1'b0, 1'b0, 1'b1);
    run_record(1, 2, 1, 1, -1, 1'b0, 1'b0, 1'b1);
    chk("auto_frames", 32'(frame_cnt), 32'd3);
    chk("auto_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle_outputs("auto_abort");
`else
    run_record(3, 4, 0, 0, -1, 1'b0, 1'b1, 1'b0);
    chk("tp1_frames", 32'(frame_cnt), 32'd1);
    run_record(0, 3, 4, 0, -1, 1'b0, 1'b1, 1'b0);
    chk("tp2_beat", 32'(beat_cnt), 32'd3);
    run_record($urandom_range(0, 4), 0, 2, 0, -1, 1'b0, 1'b1, 1'b0);
    chk("tp3_beat", 32'(beat_cnt), 32'd1);
    run_record(2, 4, 1, 2, -1, 1'b0, 1'b1, 1'b0);
    chk("tp4_ovf", 32'(ovf), 32'd1);
    chk("tp4_beat", 32'(beat_cnt), 32'd4);
    repeat (3) step();
    chk("tp4_ovf_sticky", 32'(ovf), 32'd1);
    run_record(1, 6, 0, 0, 2, 1'b1, 1'b1, 1'b0);
    chk("tp5_frames", 32'(frame_cnt), 32'(frames_exp));
    for (int i = 0; i < 8; i++) begin
      run_record($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3),
                 1, -1, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of a capture
    delay  = '0;
    reclen = CNT_W'(8);
    deind  = '0;
    arm    = 1'b1;
    step();
    arm  = 1'b0;
    step();
    trig = 1'b1;
    step();
    step();
    chk("pre_arst_capen", 32'(cap_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("arst");
    chk("arst_beat", 32'(beat_cnt), 32'd0);
    chk("arst_frame", 32'(frame_cnt), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk_idle_outputs("post_arst");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
